subtractor: RTL and testbench
=============================

// Module: subtractor
// PURPOSE
// - Unsigned WIDTH-bit subtractor: Difference = A - B (mod 2^WIDTH); Borrow flags A < B.
// - Arithmetic building block for the ALU and datapath.
// - Difference/Borrow are combinational, zero latency.
// - A registered copy (diff_q/borrow_q) serves pipelined consumers.
// PARAMETERS
// - WIDTH  32  operand/result width in bits; legal range >= 1
// PORTS
// - clk         input   1      single clock; registered outputs update on rising edge
// - rst         input   1      asynchronous, active-high reset
// - A           input   WIDTH  minuend, unsigned
// - B           input   WIDTH  subtrahend, unsigned
// - Difference  output  WIDTH  combinational A - B, low WIDTH bits (two's-complement wrap)
// - Borrow      output  1      combinational borrow-out; 1 iff A < B unsigned
// - diff_q      output  WIDTH  Difference registered on clk
// - borrow_q    output  1      Borrow registered on clk
// BEHAVIOUR
// - Combinational path:
//   - {Borrow, Difference} = {1'b0, A} - {1'b0, B}, computed over WIDTH+1 bits.
//   - Outputs settle within one propagation delay of any A/B change.
//   - No clock dependence; rst has no effect on Difference or Borrow.
// - Bit i of the ripple chain:
//   - d[i] = a[i] ^ b[i] ^ bin[i]
//   - bout[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin[i])
//   - bin[0] = 0; bin[i+1] = bout[i]; Borrow = bout[WIDTH-1].
// - Registered path:
//   - On posedge clk with rst=0: diff_q <= Difference, borrow_q <= Borrow (1-cycle latency).
//   - While rst=1, asynchronously and immediately: diff_q = 0, borrow_q = 0.
//   - Reset deassertion mid-operation: the first rising edge after deassertion captures the current A-B.
// - Boundary conditions:
//   - A == B: Difference = 0, Borrow = 0.
//   - A = 0, B = 1: Difference = all ones, Borrow = 1.
//   - A = 2^WIDTH-1, B = 0: Difference = A, Borrow = 0.
//   - A = 0, B = 2^WIDTH-1: Difference = 1, Borrow = 1.
// - X/Z on any input bit may propagate to outputs; no sanitising.
// - No handshake; inputs are sampled continuously.
// STRUCTURE
// - Shared package arith_pkg holds:
//   - localparam DATA_WIDTH = 32 (default for WIDTH);
//   - typedef logic [DATA_WIDTH-1:0] word_t.
// - Sub-module full_subtractor (ports a, b, bin -> d, bout), instantiated WIDTH times via a generate loop as a ripple-borrow chain.
// - No behavioural '-' operator in the chain; the operator is only allowed in bench reference models.
// - One always block (posedge clk or posedge rst) for diff_q/borrow_q.
// TESTING
// - A=7, B=3 -> Difference=4, Borrow=0; next clk edge -> diff_q=4, borrow_q=0.
// - A=5, B=9 -> Difference=4294967292 (32'hFFFFFFFC), Borrow=1; next clk -> diff_q=32'hFFFFFFFC, borrow_q=1.
// - A=B=32'hDEADBEEF -> Difference=0, Borrow=0; A=0, B=1 -> 32'hFFFFFFFF, Borrow=1.
// - A=0, B=32'hFFFFFFFF -> Difference=1, Borrow=1; A=32'hFFFFFFFF, B=0 -> 32'hFFFFFFFF, Borrow=0.
// - Assert rst between clock edges with nonzero A-B:
//   - diff_q and borrow_q go to 0 immediately;
//   - Difference/Borrow are unchanged;
//   - after rst drops, the first posedge loads the current result.
// - 10k random A/B pairs, checked against the reference model {Borrow,Difference} = {1'b0,A}-{1'b0,B}.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the datapath.
package arith_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell for the ripple-borrow chain.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor.sv
// Unsigned ripple-borrow subtractor with a registered copy.
module subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_q
);

  logic [WIDTH:0]   bc;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;

  assign bc[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor u_fs (
      .a    (A[i]),
      .b    (B[i]),
      .bin  (bc[i]),
      .d    (diff_d[i]),
      .bout (bc[i+1])
    );
  end

  assign borrow_d   = bc[WIDTH];
  assign Difference = diff_d;
  assign Borrow     = borrow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: tb/tb_subtractor.sv
// Bench for subtractor: directed corners, reset, random pairs.
module tb_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Difference;
  logic        Borrow;
  logic [31:0] diff_q;
  logic        borrow_q;

  int total = 0;
  int bad   = 0;

  subtractor #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .Difference (Difference),
    .Borrow     (Borrow),
    .diff_q     (diff_q),
    .borrow_q   (borrow_q)
  );

  always #5 clk = ~clk;

  // Reference: widen to 33 bits, subtract, top bit is the borrow.
  function automatic logic [32:0] ref_sub(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [32:0] obs,
    input logic [32:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] e;
    e = ref_sub(a, b);
    A = a;
    B = b;
    #1;
    chk({tag, "_comb"}, {Borrow, Difference}, e);
    @(posedge clk);
    #1;
    chk({tag, "_reg"}, {borrow_q, diff_q}, e);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    A   = 32'd0;
    B   = 32'd0;
    #2;
    chk("reset_state", {borrow_q, diff_q}, 33'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", {borrow_q, diff_q}, 33'd0);
    rst = 1'b0;

    step("a7_b3", 32'd7, 32'd3);
    chk("a7_b3_lit", {borrow_q, diff_q}, {1'b0, 32'd4});
    step("a5_b9", 32'd5, 32'd9);
    chk("a5_b9_lit", {borrow_q, diff_q},
        {1'b1, 32'hFFFF_FFFC});
    step("eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step("z_m1", 32'd0, 32'd1);
    chk("z_m1_lit", {Borrow, Difference},
        {1'b1, 32'hFFFF_FFFF});
    step("z_max", 32'd0, 32'hFFFF_FFFF);
    chk("z_max_lit", {Borrow, Difference},
        {1'b1, 32'd1});
    step("max_z", 32'hFFFF_FFFF, 32'd0);
    chk("max_z_lit", {Borrow, Difference},
        {1'b0, 32'hFFFF_FFFF});

    // Asynchronous reset between edges.
    step("pre_rst", 32'd7, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {borrow_q, diff_q}, 33'd0);
    chk("rst_comb", {Borrow, Difference}, {1'b0, 32'd4});
    A = 32'd5;
    B = 32'd9;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_low_hold", {borrow_q, diff_q}, 33'd0);
    @(posedge clk);
    #1;
    chk("rst_first_load", {borrow_q, diff_q},
        {1'b1, 32'hFFFF_FFFC});

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ra;
      if (i % 7 == 0) rb = ra + 32'd1;
      step("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
